// File: rtl/mm_lookup_ctrl_if.sv
// Requester channel of the lookup controller: request (key) handshake and
// response (data/status) handshake for a single requester.
interface mm_lookup_ctrl_if #(
    parameter int KEY_W  = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [KEY_W-1:0]  req_key;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;

    modport master (
        output req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_status
    );

    modport slave (
        input  req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/mm_lookup_ctrl.sv
// Lookup sequencer for the 16-entry matching memory: round-robin arbitration of
// two requesters, fixed-latency key presentation, hit/miss/multi classification.
module mm_lookup_ctrl #(
    parameter int KEY_W     = 32,
    parameter int DATA_W    = 32,
    parameter int ENTRIES   = 16,
    parameter int MATCH_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mm_lookup_ctrl_if.slave     req0_if,
    mm_lookup_ctrl_if.slave     req1_if,
    output logic [KEY_W-1:0]    o_mm_key,
    output logic                o_mm_key_vld,
    input  logic [ENTRIES-1:0]  i_mm_mtch_rslt,
    input  logic [DATA_W-1:0]   i_mm_data,
    output logic                o_busy,
    output logic [7:0]          o_multihit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rr_last;
    logic              r_id;
    logic [KEY_W-1:0]  r_key;
    logic [3:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_rsp_status;
    logic [7:0]        r_mh_cnt;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_sample;
    logic              w_rsp_hs;
    logic              w_zero;
    logic              w_one;
    logic [ENTRIES-1:0] w_mtch_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        o_mm_key_vld = 1'b0;
        w_sample     = 1'b0;
        w_rsp_hs     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the requester not served last wins.
                w_gnt0 = req0_if.req_valid & (~req1_if.req_valid | r_rr_last);
                w_gnt1 = req1_if.req_valid & (~req0_if.req_valid | ~r_rr_last);
                if (w_gnt0 | w_gnt1) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                o_mm_key_vld = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_hs = r_id ? req1_if.rsp_ready : req0_if.rsp_ready;
                if (w_rsp_hs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
    assign w_mtch_dec = i_mm_mtch_rslt - {{(ENTRIES-1){1'b0}}, 1'b1};
    assign w_zero     = ~|i_mm_mtch_rslt;
    assign w_one      = ~w_zero & ~|(i_mm_mtch_rslt & w_mtch_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last    <= 1'b1;
            r_id         <= 1'b0;
            r_key        <= '0;
            r_wait_cnt   <= 4'd0;
            r_rsp_data   <= '0;
            r_rsp_status <= 2'b00;
            r_mh_cnt     <= 8'd0;
        end else begin
            if (w_gnt0 | w_gnt1) begin
                r_key     <= w_gnt0 ? req0_if.req_key : req1_if.req_key;
                r_id      <= w_gnt1;
                r_rr_last <= w_gnt1;
            end
            if (r_state == S_ISSUE)
                r_wait_cnt <= 4'(MATCH_LAT - 1);
            else if (r_state == S_WAIT && r_wait_cnt != 4'd0)
                r_wait_cnt <= r_wait_cnt - 4'd1;
            if (w_sample) begin
                if (w_one) begin
                    r_rsp_data   <= i_mm_data;
                    r_rsp_status <= 2'b00;
                end else if (w_zero) begin
                    r_rsp_data   <= '0;
                    r_rsp_status <= 2'b01;
                end else begin
                    r_rsp_data   <= '0;
                    r_rsp_status <= 2'b10;
                    if (r_mh_cnt != 8'hFF) r_mh_cnt <= r_mh_cnt + 8'd1;
                end
            end
        end
    end

    assign req0_if.req_ready  = w_gnt0;
    assign req1_if.req_ready  = w_gnt1;
    assign req0_if.rsp_valid  = (r_state == S_RESP) & ~r_id;
    assign req1_if.rsp_valid  = (r_state == S_RESP) & r_id;
    assign req0_if.rsp_data   = r_rsp_data;
    assign req1_if.rsp_data   = r_rsp_data;
    assign req0_if.rsp_status = r_rsp_status;
    assign req1_if.rsp_status = r_rsp_status;

    assign o_mm_key       = r_key;
    assign o_busy         = (r_state != S_IDLE);
    assign o_multihit_cnt = r_mh_cnt;

endmodule

// File: tb/tb_mm_lookup_ctrl.sv
// Scoreboard bench for mm_lookup_ctrl: directed lookups, a latency-accurate
// matching-memory model, and a monitor that checks every response handshake.
module tb_mm_lookup_ctrl;
    localparam int KEY_W     = 32;
    localparam int DATA_W    = 32;
    localparam int ENTRIES   = 16;
    localparam int MATCH_LAT = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [KEY_W-1:0]   mm_key;
    logic               mm_key_vld;
    logic [ENTRIES-1:0] mm_mtch = '1;
    logic [DATA_W-1:0]  mm_data = 32'hDEADBEEF;
    logic               busy;
    logic [7:0]         mh_cnt;

    mm_lookup_ctrl_if #(.KEY_W(KEY_W), .DATA_W(DATA_W)) req0_if ();
    mm_lookup_ctrl_if #(.KEY_W(KEY_W), .DATA_W(DATA_W)) req1_if ();

    mm_lookup_ctrl #(
        .KEY_W(KEY_W), .DATA_W(DATA_W), .ENTRIES(ENTRIES), .MATCH_LAT(MATCH_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_if        (req0_if.slave),
        .req1_if        (req1_if.slave),
        .o_mm_key       (mm_key),
        .o_mm_key_vld   (mm_key_vld),
        .i_mm_mtch_rslt (mm_mtch),
        .i_mm_data      (mm_data),
        .o_busy         (busy),
        .o_multihit_cnt (mh_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [1:0]  status;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    int   kv_cnt = 0;
    int   acc_cnt = 0;
    logic [15:0] tab_m [bit [31:0]];
    logic [31:0] tab_d [bit [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Matching memory: valid match/data only in the result-valid cycle, junk otherwise.
    int mm_cnt = -1;
    always @(negedge clk) begin
        if (!rst_n)                          mm_cnt = -1;
        else if (mm_key_vld)                 mm_cnt = 0;
        else if (mm_cnt >= 0)                mm_cnt = mm_cnt + 1;
        if (mm_cnt == MATCH_LAT && tab_m.exists(mm_key)) begin
            mm_mtch = tab_m[mm_key];
            mm_data = tab_d[mm_key];
        end else begin
            mm_mtch = 16'hFFFF;
            mm_data = 32'hDEADBEEF;
        end
    end

    logic prev_v0 = 1'b0, prev_v1 = 1'b0, prev_kv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            prev_v0 = 1'b0;
            prev_v1 = 1'b0;
            prev_kv = 1'b0;
        end else begin
            if (req0_if.req_ready && req1_if.req_ready) fail("dual_ready", "both req_ready high");
            if (req0_if.req_valid && req0_if.req_ready) begin acc_q.push_back(cyc); acc_cnt++; end
            if (req1_if.req_valid && req1_if.req_ready) begin acc_q.push_back(cyc); acc_cnt++; end
            if (mm_key_vld) begin
                kv_cnt++;
                if (prev_kv) fail("key_vld_width", "mm_key_vld high two cycles in a row");
            end
            prev_kv = mm_key_vld;
            if (req0_if.rsp_valid && req1_if.rsp_valid) fail("dual_rsp", "both rsp_valid high");
            if ((req0_if.rsp_valid && !prev_v0) || (req1_if.rsp_valid && !prev_v1)) begin
                if (acc_q.size() == 0) fail("rsp_unexpected", "rsp_valid without accepted request");
                else chk("rsp_latency", cyc - acc_q.pop_front() - 1, MATCH_LAT + 1);
            end
            prev_v0 = req0_if.rsp_valid;
            prev_v1 = req1_if.rsp_valid;
            if ((req0_if.rsp_valid && req0_if.rsp_ready) || (req1_if.rsp_valid && req1_if.rsp_ready)) begin
                if (exp_q.size() == 0) fail("rsp_extra", "response with empty scoreboard");
                else begin
                    exp_t e;
                    logic id;
                    e  = exp_q.pop_front();
                    id = req1_if.rsp_valid;
                    chk("rsp_id", id, e.id);
                    chk("rsp_data", id ? req1_if.rsp_data : req0_if.rsp_data, e.data);
                    chk("rsp_status", id ? req1_if.rsp_status : req0_if.rsp_status, e.status);
                end
            end
        end
    end

    task automatic push_exp(input logic id, input logic [31:0] d, input logic [1:0] st);
        exp_t e;
        e.id = id; e.data = d; e.status = st;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic id, input logic [31:0] key, input logic [15:0] m,
                         input logic [31:0] d, input logic [1:0] est, input logic [31:0] ed,
                         input bit push);
        bit got = 0;
        tab_m[key] = m;
        tab_d[key] = d;
        if (push) push_exp(id, ed, est);
        @(posedge clk); #1;
        if (id == 1'b0) begin req0_if.req_key = key; req0_if.req_valid = 1'b1; end
        else            begin req1_if.req_key = key; req1_if.req_valid = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (id == 1'b0 ? (req0_if.req_valid && req0_if.req_ready)
                           : (req1_if.req_valid && req1_if.req_ready)) begin
                got = 1;
                break;
            end
        end
        if (!got) fail("accept_timeout", $sformatf("requester %0d key %0h", id, key));
        @(posedge clk); #1;
        if (id == 1'b0) req0_if.req_valid = 1'b0;
        else            req1_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin done = 1; break; end
        end
        if (!done) fail("idle_timeout", "lookup did not complete");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_key_vld"}, mm_key_vld, 0);
        chk({tag, "_mm_key"}, mm_key, 0);
        chk({tag, "_mh_cnt"}, mh_cnt, 0);
        chk({tag, "_rsp_valid"}, {req0_if.rsp_valid, req1_if.rsp_valid}, 0);
        chk({tag, "_rsp_data"}, {req0_if.rsp_data, req1_if.rsp_data}, 0);
        chk({tag, "_rsp_status"}, {req0_if.rsp_status, req1_if.rsp_status}, 0);
        chk({tag, "_req_ready"}, {req0_if.req_ready, req1_if.req_ready}, 0);
    endtask

    initial begin
        req0_if.req_valid = 0; req0_if.req_key = '0; req0_if.rsp_ready = 1;
        req1_if.req_valid = 0; req1_if.req_key = '0; req1_if.rsp_ready = 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #2 rst_n = 1'b1;

        // T1: single hit
        issue(0, 32'hA5, 16'h0040, 32'h1234_5678, 2'b00, 32'h1234_5678, 1);
        wait_idle();

        // T2: miss then multi-hit
        issue(0, 32'h100, 16'h0000, 32'hFFFF_0000, 2'b01, 32'h0, 1);
        issue(1, 32'h101, 16'h8001, 32'h55AA_55AA, 2'b10, 32'h0, 1);
        wait_idle();
        chk("mh_cnt_t2", mh_cnt, 1);

        // T3: continuous contention, expected grant order 0,1,0,1
        push_exp(0, 32'h1111_1111, 2'b00);
        push_exp(1, 32'h2222_2222, 2'b00);
        push_exp(0, 32'h0,         2'b01);
        push_exp(1, 32'h0,         2'b10);
        fork
            begin
                issue(0, 32'h200, 16'h0001, 32'h1111_1111, 2'b00, 32'h0, 0);
                issue(0, 32'h202, 16'h0000, 32'h3333_3333, 2'b00, 32'h0, 0);
            end
            begin
                issue(1, 32'h201, 16'h8000, 32'h2222_2222, 2'b00, 32'h0, 0);
                issue(1, 32'h203, 16'h0018, 32'h4444_4444, 2'b00, 32'h0, 0);
            end
        join
        wait_idle();
        chk("mh_cnt_t3", mh_cnt, 2);

        // T4: backpressure on requester 1 while requester 0 waits
        req1_if.rsp_ready = 0;
        issue(1, 32'h300, 16'h0200, 32'hABCD_0123, 2'b00, 32'hABCD_0123, 1);
        push_exp(0, 32'h0F0F_0F0F, 2'b00);
        fork
            issue(0, 32'h301, 16'h0004, 32'h0F0F_0F0F, 2'b00, 32'h0, 0);
            begin
                bit seen = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (req1_if.rsp_valid) begin seen = 1; break; end
                end
                if (!seen) fail("bp_timeout", "rsp1_valid never rose");
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_rsp1_valid", req1_if.rsp_valid, 1);
                    chk("bp_rsp1_data", req1_if.rsp_data, 32'hABCD_0123);
                    chk("bp_rsp1_status", req1_if.rsp_status, 2'b00);
                    chk("bp_busy", busy, 1);
                    chk("bp_req0_ready", req0_if.req_ready, 0);
                end
                @(posedge clk); #1;
                req1_if.rsp_ready = 1;
            end
        join
        wait_idle();

        // T5: multi-hit counter saturation
        for (int i = 0; i < 252; i++)
            issue(0, 32'h400, 16'hC000, 32'h99, 2'b10, 32'h0, 1);
        wait_idle();
        chk("mh_cnt_254", mh_cnt, 254);
        issue(0, 32'h400, 16'hC000, 32'h99, 2'b10, 32'h0, 1);
        wait_idle();
        chk("mh_cnt_255", mh_cnt, 255);
        for (int i = 0; i < 47; i++)
            issue(0, 32'h400, 16'hC000, 32'h99, 2'b10, 32'h0, 1);
        wait_idle();
        chk("mh_cnt_sat", mh_cnt, 255);

        // Reset during WAIT aborts the lookup
        issue(0, 32'h500, 16'h0001, 32'h77, 2'b00, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort_rsp", {req0_if.rsp_valid, req1_if.rsp_valid, busy}, 0);
        end

        // First tie after reset goes to requester 0
        push_exp(0, 32'h6060_6060, 2'b00);
        push_exp(1, 32'h6161_6161, 2'b00);
        fork
            issue(0, 32'h600, 16'h0002, 32'h6060_6060, 2'b00, 32'h0, 0);
            issue(1, 32'h601, 16'h0100, 32'h6161_6161, 2'b00, 32'h0, 0);
        join
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("key_vld_per_lookup", kv_cnt, acc_cnt);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
